if_id_pipe_reg: RTL and testbench

Parametrised IF/ID pipeline register with a valid/ready handshake, a one-entry skid buffer, a flush that squashes in-flight instructions to a NOP bubble, and a saturating stall counter. It sits between fetch (PC/instruction memory) and decode. It replaces the fixed 32-bit register that has no stall or flush.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_skid_buf.sv | 77 +++++++
 rtl/if_id_pipe_reg.sv | 96 +++++++++
 tb/tb_if_id_pipe_reg.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: default widths, the NOP encoding and
// the IF/ID payload layout. Later stage registers (ID/EX, EX/MEM) reuse it.
package pipe_pkg;

  localparam int          XLEN_DEF = 32;
  localparam logic [31:0] NOP_ENC  = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] pc_plus_4;
    logic [XLEN_DEF-1:0] instr;
  } if_id_payload;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'd0,
    SB_FULL  = 2'd1,
    SB_SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register with a one-entry skid buffer. The registered
// in_ready drops only once both the main and skid entries are occupied.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 96
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q;
  logic         in_ready_q;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire, out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = (state_q != SB_EMPTY) && out_ready;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    case (state_q)
      SB_EMPTY: if (in_fire) main_d = in_data;
      SB_FULL: begin
        if (in_fire && out_fire) main_d = in_data;
        else if (in_fire)        skid_d = in_data;
      end
      SB_SKID:  if (out_fire) main_d = skid_q;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK) begin
    main_q <= main_d;
    skid_q <= skid_d;
    if (reset || clear) begin
      state_q    <= SB_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        SB_EMPTY: if (in_fire) state_q <= SB_FULL;
        SB_FULL: begin
          if (in_fire && !out_fire) begin
            state_q    <= SB_SKID;
            in_ready_q <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state_q <= SB_EMPTY;
          end
        end
        SB_SKID: begin
          if (out_fire) begin
            state_q    <= SB_FULL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= SB_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: handshake (optionally skid-buffered), flush to a NOP
// bubble, and a saturating count of decode backpressure cycles.
module if_id_pipe_reg
  import pipe_pkg::*;
#(
  parameter int             XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_ENC),
  parameter bit             SKID_EN   = 1'b1,
  parameter int             CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_pc_plus_4,
  input  logic [XLEN-1:0]  in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_plus_4,
  output logic [XLEN-1:0]  out_instr,
  output logic [CNT_W-1:0] stall_count
);

  localparam int PW = 3 * XLEN;

  logic [PW-1:0]    in_data, main_data;
  logic             main_valid;
  logic [CNT_W-1:0] stall_q, stall_d;

  assign in_data = {in_pc, in_pc_plus_4, in_instr};

  generate
    if (SKID_EN) begin : g_skid
      pipe_skid_buf #(.W(PW)) u_skid_buf (
        .CLK       (CLK),
        .reset     (reset),
        .clear     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (main_valid),
        .out_ready (out_ready),
        .out_data  (main_data)
      );
    end else begin : g_single
      logic          valid_q, valid_d;
      logic [PW-1:0] data_q, data_d;

      assign in_ready = !valid_q || out_ready;

      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
          valid_d = 1'b1;
          data_d  = in_data;
        end else if (out_ready) begin
          valid_d = 1'b0;
        end
        if (flush) valid_d = 1'b0;
      end

      always_ff @(posedge CLK) begin
        data_q <= data_d;
        if (reset) valid_q <= 1'b0;
        else       valid_q <= valid_d;
      end

      assign main_valid = valid_q;
      assign main_data  = data_q;
    end
  endgenerate

  // Masking by valid gives the reset/flush values without resetting the data path.
  assign out_valid     = main_valid;
  assign out_pc        = main_valid ? main_data[PW-1 -: XLEN]     : '0;
  assign out_pc_plus_4 = main_valid ? main_data[2*XLEN-1 -: XLEN] : '0;
  assign out_instr     = main_valid ? main_data[XLEN-1:0]         : NOP_INSTR;

  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a skid-buffered instance (CNT_W=4) and a
// single-register instance, each checked against a queue-based model.
module tb_if_id_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } pl_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset = 1'b1;
  // instance a: SKID_EN=1, CNT_W=4
  logic        in_valid_a = 0, in_ready_a, flush_a = 0, out_valid_a, out_ready_a = 0;
  logic [31:0] in_pc_a = 0, in_pc_plus_4_a = 0, in_instr_a = 0;
  logic [31:0] out_pc_a, out_pc_plus_4_a, out_instr_a;
  logic [3:0]  stall_count_a;
  // instance b: SKID_EN=0, CNT_W=16
  logic        in_valid_b = 0, in_ready_b, flush_b = 0, out_valid_b, out_ready_b = 0;
  logic [31:0] in_pc_b = 0, in_pc_plus_4_b = 0, in_instr_b = 0;
  logic [31:0] out_pc_b, out_pc_plus_4_b, out_instr_b;
  logic [15:0] stall_count_b;

  if_id_pipe_reg #(.SKID_EN(1'b1), .CNT_W(4)) dut_a (
    .CLK(CLK), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_pc(in_pc_a), .in_pc_plus_4(in_pc_plus_4_a), .in_instr(in_instr_a),
    .flush(flush_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_pc(out_pc_a), .out_pc_plus_4(out_pc_plus_4_a), .out_instr(out_instr_a),
    .stall_count(stall_count_a)
  );

  if_id_pipe_reg #(.SKID_EN(1'b0), .CNT_W(16)) dut_b (
    .CLK(CLK), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_pc(in_pc_b), .in_pc_plus_4(in_pc_plus_4_b), .in_instr(in_instr_b),
    .flush(flush_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_pc(out_pc_b), .out_pc_plus_4(out_pc_plus_4_b), .out_instr(out_instr_b),
    .stall_count(stall_count_b)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  pl_t         qa[$], qb[$];
  logic [3:0]  st_a = '0;
  logic [15:0] st_b = '0;
  bit          known = 1'b0;
  int          n_vec = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic drv_a(input logic [31:0] pc, input logic [31:0] instr);
    in_valid_a = 1'b1; in_pc_a = pc; in_pc_plus_4_a = pc + 32'd4; in_instr_a = instr;
  endtask

  task automatic drv_b(input logic [31:0] pc, input logic [31:0] instr);
    in_valid_b = 1'b1; in_pc_b = pc; in_pc_plus_4_b = pc + 32'd4; in_instr_b = instr;
  endtask

  // Compare outputs against the model, advance the model, then step one clock.
  task automatic cycle();
    logic va, vb, ra, rb;
    pl_t  ha, hb;
    @(negedge CLK);
    va = (qa.size() > 0);
    ra = (qa.size() < 2);
    vb = (qb.size() > 0);
    rb = (qb.size() == 0) || out_ready_b;
    ha = '{pc: 32'h0, pc4: 32'h0, instr: NOP};
    hb = '{pc: 32'h0, pc4: 32'h0, instr: NOP};
    if (va) ha = qa[0];
    if (vb) hb = qb[0];
    if (known) begin
      check_val("a_out_valid", 32'(out_valid_a), 32'(va));
      check_val("a_in_ready",  32'(in_ready_a),  32'(ra));
      check_val("a_out_pc",    out_pc_a,        ha.pc);
      check_val("a_out_pc4",   out_pc_plus_4_a, ha.pc4);
      check_val("a_out_instr", out_instr_a,     ha.instr);
      check_val("a_stall",     32'(stall_count_a), 32'(st_a));
      check_val("b_out_valid", 32'(out_valid_b), 32'(vb));
      check_val("b_in_ready",  32'(in_ready_b),  32'(rb));
      check_val("b_out_pc",    out_pc_b,        hb.pc);
      check_val("b_out_pc4",   out_pc_plus_4_b, hb.pc4);
      check_val("b_out_instr", out_instr_b,     hb.instr);
      check_val("b_stall",     32'(stall_count_b), 32'(st_b));
    end
    if (reset) begin
      qa.delete(); qb.delete(); st_a = '0; st_b = '0;
    end else begin
      if (va && !out_ready_a && !flush_a && st_a != 4'hF) st_a++;
      if (vb && !out_ready_b && !flush_b && st_b != 16'hFFFF) st_b++;
      if (flush_a) qa.delete();
      else begin
        if (va && out_ready_a) void'(qa.pop_front());
        if (in_valid_a && ra) qa.push_back('{pc: in_pc_a, pc4: in_pc_plus_4_a, instr: in_instr_a});
      end
      if (flush_b) qb.delete();
      else begin
        if (vb && out_ready_b) void'(qb.pop_front());
        if (in_valid_b && rb) qb.push_back('{pc: in_pc_b, pc4: in_pc_plus_4_b, instr: in_instr_b});
      end
    end
    @(posedge CLK);
    if (reset) known = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;

    // streaming at full throughput
    out_ready_a = 1'b1;
    foreach (qa[i]) ;
    for (int i = 0; i < 3; i++) begin
      drv_a(32'(i * 4), 32'h0010_0093 + 32'(i));
      cycle();
    end
    in_valid_a = 1'b0;
    cycle(); cycle();

    // backpressure fills main and skid
    out_ready_a = 1'b0;
    drv_a(32'h10, 32'h0020_0113); cycle();
    drv_a(32'h14, 32'h0030_0193); cycle();
    in_valid_a = 1'b0; cycle();
    out_ready_a = 1'b1;
    cycle(); cycle(); cycle();

    // flush while in SKID with a simultaneous incoming entry
    out_ready_a = 1'b0;
    drv_a(32'h18, 32'h0040_0213); cycle();
    drv_a(32'h1c, 32'h0050_0293); cycle();
    in_valid_a = 1'b0; cycle();
    flush_a = 1'b1; drv_a(32'h20, 32'h0060_0313); cycle();
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    cycle(); cycle();

    // reset while an entry is held
    out_ready_a = 1'b0;
    drv_a(32'h30, 32'h0050_0093); cycle();
    in_valid_a = 1'b0; cycle();
    reset = 1'b1; cycle();
    reset = 1'b0; cycle();

    // stall counter saturation
    drv_a(32'h40, 32'h0070_0393); cycle();
    in_valid_a = 1'b0;
    repeat (20) cycle();
    out_ready_a = 1'b1;
    cycle(); cycle();

    // single-register variant: combinational in_ready
    out_ready_b = 1'b0;
    drv_b(32'h100, 32'h0080_0413); cycle();
    drv_b(32'h104, 32'h0090_0493); cycle();
    cycle();
    out_ready_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv_b(32'h108 + 32'(i * 4), 32'h00a0_0513 + 32'(i)); cycle();
    end
    in_valid_b = 1'b0;
    cycle(); cycle();

    // random traffic on both instances
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) drv_a(32'h1000 + 32'(i * 4), $urandom);
      else in_valid_a = 1'b0;
      if ($urandom_range(0, 3) != 0) drv_b(32'h2000 + 32'(i * 4), $urandom);
      else in_valid_b = 1'b0;
      out_ready_a = ($urandom_range(0, 2) != 0);
      out_ready_b = ($urandom_range(0, 2) != 0);
      flush_a = ($urandom_range(0, 15) == 0);
      flush_b = ($urandom_range(0, 15) == 0);
      cycle();
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    cycle(); cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
